// File: rtl/bit_timing_controller.sv
// CAN bit-time sequencer: divides the clock into time quanta and walks SYNC/PROP/PHASE1/PHASE2,
// applying hard sync and once-per-bit resynchronisation corrections.
module bit_timing_controller #(
  parameter int unsigned BRP_WIDTH = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [BRP_WIDTH-1:0] baud_rate_prescaler,
  input  logic [3:0]           propagation_segment,
  input  logic [3:0]           phase_segment_1,
  input  logic [3:0]           phase_segment_2,
  input  logic                 hard_sync_request,
  input  logic                 resync_required,
  input  logic [3:0]           resync_adjustment,
  input  logic                 resync_direction,
  output logic                 time_quantum_tick,
  output logic [1:0]           current_segment,
  output logic [4:0]           quanta_counter,
  output logic                 sample_point,
  output logic                 bit_start
);

  typedef enum logic [1:0] {
    SEG_SYNC   = 2'b00,
    SEG_PROP   = 2'b01,
    SEG_PHASE1 = 2'b10,
    SEG_PHASE2 = 2'b11
  } seg_t;

  seg_t                 r_seg;
  logic [BRP_WIDTH-1:0] r_prescaler;
  logic [4:0]           r_qc;
  logic                 r_tick;
  logic                 r_sample;
  logic                 r_bit_start;
  logic [3:0]           r_ps1_ext;
  logic [3:0]           r_ps2_cut;
  logic                 r_resync_used;

  logic                 w_wrap;
  logic [3:0]           w_ps1_nom;
  logic [3:0]           w_ps2_nom;
  logic [4:0]           w_ps1_eff;
  logic signed [5:0]    w_ps2_diff;
  logic [4:0]           w_ps2_eff;
  logic [5:0]           w_qc_next;
  logic                 w_seg_end;
  seg_t                 w_seg_next;
  logic                 w_accept_ext;
  logic                 w_accept_cut;

  always_comb begin
    w_wrap     = enable && (r_prescaler == baud_rate_prescaler);
    w_ps1_nom  = (phase_segment_1 == '0) ? 4'd1 : phase_segment_1;
    w_ps2_nom  = (phase_segment_2 == '0) ? 4'd1 : phase_segment_2;
    w_ps1_eff  = {1'b0, w_ps1_nom} + {1'b0, r_ps1_ext};
    // Signed headroom so an over-sized cut saturates at 1 tq instead of wrapping.
    w_ps2_diff = $signed({2'b00, w_ps2_nom}) - $signed({2'b00, r_ps2_cut});
    w_ps2_eff  = (w_ps2_diff < 6'sd1) ? 5'd1 : w_ps2_diff[4:0];
    w_qc_next  = {1'b0, r_qc} + 6'd1;

    w_seg_end  = 1'b0;
    w_seg_next = r_seg;
    unique case (r_seg)
      SEG_SYNC: begin
        w_seg_end  = 1'b1;
        w_seg_next = (propagation_segment == '0) ? SEG_PHASE1 : SEG_PROP;
      end
      SEG_PROP: begin
        w_seg_end  = (w_qc_next == {2'b00, propagation_segment});
        w_seg_next = SEG_PHASE1;
      end
      SEG_PHASE1: begin
        w_seg_end  = (w_qc_next >= {1'b0, w_ps1_eff});
        w_seg_next = SEG_PHASE2;
      end
      SEG_PHASE2: begin
        w_seg_end  = (w_qc_next >= {1'b0, w_ps2_eff});
        w_seg_next = SEG_SYNC;
      end
      default: begin
        w_seg_end  = 1'b0;
        w_seg_next = SEG_SYNC;
      end
    endcase

    w_accept_ext = enable && resync_required && !hard_sync_request && !r_resync_used &&
                   !resync_direction && ((r_seg == SEG_PROP) || (r_seg == SEG_PHASE1));
    w_accept_cut = enable && resync_required && !hard_sync_request && !r_resync_used &&
                   resync_direction && (r_seg == SEG_PHASE2);
  end

  always_ff @(posedge clock) begin
    if (reset || !enable) begin
      r_prescaler   <= '0;
      r_seg         <= SEG_SYNC;
      r_qc          <= '0;
      r_tick        <= 1'b0;
      r_sample      <= 1'b0;
      r_bit_start   <= 1'b0;
      r_ps1_ext     <= '0;
      r_ps2_cut     <= '0;
      r_resync_used <= 1'b0;
    end else if (hard_sync_request) begin
      r_prescaler   <= '0;
      r_seg         <= SEG_SYNC;
      r_qc          <= '0;
      r_tick        <= 1'b0;
      r_sample      <= 1'b0;
      r_bit_start   <= 1'b1;
      r_ps1_ext     <= '0;
      r_ps2_cut     <= '0;
      r_resync_used <= 1'b0;
    end else begin
      r_tick      <= w_wrap;
      r_sample    <= 1'b0;
      r_bit_start <= 1'b0;
      if (w_accept_ext) begin
        r_ps1_ext     <= resync_adjustment;
        r_resync_used <= 1'b1;
      end
      if (w_accept_cut) begin
        r_ps2_cut     <= resync_adjustment;
        r_resync_used <= 1'b1;
      end
      if (w_wrap) begin
        r_prescaler <= '0;
        if (w_seg_end) begin
          r_seg <= w_seg_next;
          r_qc  <= '0;
          if (w_seg_next == SEG_PHASE2) r_sample <= 1'b1;
          // New bit: clearing here overrides any correction accepted in this same cycle.
          if (w_seg_next == SEG_SYNC) begin
            r_bit_start   <= 1'b1;
            r_ps1_ext     <= '0;
            r_ps2_cut     <= '0;
            r_resync_used <= 1'b0;
          end
        end else begin
          r_qc <= w_qc_next[4:0];
        end
      end else begin
        r_prescaler <= r_prescaler + BRP_WIDTH'(1);
      end
    end
  end

  assign time_quantum_tick = r_tick;
  assign current_segment   = r_seg;
  assign quanta_counter    = r_qc;
  assign sample_point      = r_sample;
  assign bit_start         = r_bit_start;

endmodule

// File: tb/tb_bit_timing_controller.sv
// Bench for bit_timing_controller: directed bit-length scenarios plus randomized traffic
// compared every cycle against a position-within-bit reference model.
module tb_bit_timing_controller;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [5:0] baud_rate_prescaler;
  logic [3:0] propagation_segment;
  logic [3:0] phase_segment_1;
  logic [3:0] phase_segment_2;
  logic       hard_sync_request;
  logic       resync_required;
  logic [3:0] resync_adjustment;
  logic       resync_direction;
  logic       time_quantum_tick;
  logic [1:0] current_segment;
  logic [4:0] quanta_counter;
  logic       sample_point;
  logic       bit_start;

  bit_timing_controller #(.BRP_WIDTH(6)) dut (
    .clock              (clock),
    .reset              (reset),
    .enable             (enable),
    .baud_rate_prescaler(baud_rate_prescaler),
    .propagation_segment(propagation_segment),
    .phase_segment_1    (phase_segment_1),
    .phase_segment_2    (phase_segment_2),
    .hard_sync_request  (hard_sync_request),
    .resync_required    (resync_required),
    .resync_adjustment  (resync_adjustment),
    .resync_direction   (resync_direction),
    .time_quantum_tick  (time_quantum_tick),
    .current_segment    (current_segment),
    .quanta_counter     (quanta_counter),
    .sample_point       (sample_point),
    .bit_start          (bit_start)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int bs_q[$];
  int sp_q[$];

  // Reference model: tq position inside the current bit, plus where PHASE2 began.
  int m_clk = 0, m_pos = 0, m_p2start = 0, m_ext = 0, m_cut = 0;
  bit m_p2 = 0, m_used = 0;
  bit e_tick = 0, e_sample = 0, e_bs = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic m_clear();
    m_clk = 0; m_pos = 0; m_p2 = 0; m_p2start = 0;
    m_ext = 0; m_cut = 0; m_used = 0;
  endtask

  task automatic m_step();
    int prop, ps1eff, ps2eff, n_ext, n_cut;
    bit wrap, in_prop, in_ph1, n_used;
    if (reset || !enable) begin
      m_clear(); e_tick = 0; e_sample = 0; e_bs = 0;
      return;
    end
    if (hard_sync_request) begin
      m_clear(); e_tick = 0; e_sample = 0; e_bs = 1;
      return;
    end
    prop   = int'(propagation_segment);
    ps1eff = ((phase_segment_1 == 0) ? 1 : int'(phase_segment_1)) + m_ext;
    ps2eff = ((phase_segment_2 == 0) ? 1 : int'(phase_segment_2)) - m_cut;
    if (ps2eff < 1) ps2eff = 1;
    wrap    = (m_clk == int'(baud_rate_prescaler));
    in_prop = !m_p2 && m_pos >= 1 && m_pos <= prop;
    in_ph1  = !m_p2 && m_pos > prop;
    e_tick = wrap; e_sample = 0; e_bs = 0;
    n_ext = m_ext; n_cut = m_cut; n_used = m_used;
    if (resync_required && !m_used) begin
      if (!resync_direction && (in_prop || in_ph1)) begin n_ext = int'(resync_adjustment); n_used = 1; end
      if (resync_direction && m_p2) begin n_cut = int'(resync_adjustment); n_used = 1; end
    end
    if (wrap) begin
      m_clk = 0;
      if (m_p2 && (m_pos + 1 - m_p2start >= ps2eff)) begin
        m_pos = 0; m_p2 = 0; e_bs = 1;
        n_ext = 0; n_cut = 0; n_used = 0;
      end else if (in_ph1 && (m_pos + 1 >= 1 + prop + ps1eff)) begin
        m_pos++; m_p2 = 1; m_p2start = m_pos; e_sample = 1;
      end else m_pos++;
    end else m_clk++;
    m_ext = n_ext; m_cut = n_cut; m_used = n_used;
  endtask

  task automatic step();
    int es, eq;
    @(posedge clock);
    m_step();
    #1;
    cyc++;
    if (m_p2) begin es = 3; eq = m_pos - m_p2start; end
    else if (m_pos == 0) begin es = 0; eq = 0; end
    else if (m_pos <= int'(propagation_segment)) begin es = 1; eq = m_pos - 1; end
    else begin es = 2; eq = m_pos - 1 - int'(propagation_segment); end
    check_eq("tick", int'(time_quantum_tick), int'(e_tick));
    check_eq("segment", int'(current_segment), es);
    check_eq("quanta", int'(quanta_counter), eq);
    check_eq("sample_point", int'(sample_point), int'(e_sample));
    check_eq("bit_start", int'(bit_start), int'(e_bs));
    if (bit_start) bs_q.push_back(cyc);
    if (sample_point) sp_q.push_back(cyc);
  endtask

  task automatic clear_q();
    bs_q.delete(); sp_q.delete();
  endtask

  task automatic wait_bs(input int n, input string tag);
    int k = 0;
    while (bs_q.size() < n && k < 300) begin step(); k++; end
    check_eq(tag, int'(bs_q.size() >= n), 1);
  endtask

  task automatic wait_seg(input int seg, input int qc, input string tag);
    int k = 0;
    while (!(int'(current_segment) == seg && (qc < 0 || int'(quanta_counter) == qc)) && k < 300) begin
      step(); k++;
    end
    check_eq(tag, int'(k < 300), 1);
  endtask

  task automatic pulse_rr(input bit dir, input int adj);
    resync_required = 1; resync_direction = dir; resync_adjustment = 4'(adj);
    step();
    resync_required = 0;
  endtask

  function automatic int gap(input int i);
    if (bs_q.size() > i + 1) return bs_q[i+1] - bs_q[i];
    return -1;
  endfunction

  function automatic int sp_after(input int t);
    foreach (sp_q[i]) if (sp_q[i] > t) return sp_q[i];
    return -1000;
  endfunction

  task automatic set_cfg(input int brp, input int prop, input int ps1, input int ps2);
    baud_rate_prescaler = 6'(brp); propagation_segment = 4'(prop);
    phase_segment_1 = 4'(ps1); phase_segment_2 = 4'(ps2);
  endtask

  initial begin
    reset = 1; enable = 0; hard_sync_request = 0; resync_required = 0;
    resync_adjustment = 0; resync_direction = 0;
    set_cfg(1, 2, 3, 3);
    step(); step();
    check_eq("rst_segment", int'(current_segment), 0);
    check_eq("rst_bit_start", int'(bit_start), 0);

    // Free run: 9 tq of 2 clocks, sample 6 tq in.
    reset = 0; enable = 1; clear_q();
    wait_bs(3, "free_bs_timeout");
    check_eq("free_period0", gap(0), 18);
    check_eq("free_period1", gap(1), 18);
    check_eq("free_sp_offset", sp_after(bs_q[0]) - bs_q[0], 12);

    // Lengthen PHASE1 by 2 tq during PROP.
    clear_q(); wait_bs(1, "r0_sync_timeout");
    wait_seg(1, -1, "r0_prop_timeout");
    pulse_rr(0, 2);
    wait_bs(3, "r0_bs_timeout");
    check_eq("resync_lengthen_bit", gap(0), 22);
    check_eq("resync_following_bit", gap(1), 18);

    // Shorten PHASE2 by 2 tq at its first tq.
    clear_q(); wait_bs(1, "r1_sync_timeout");
    wait_seg(3, 0, "r1_ph2_timeout");
    pulse_rr(1, 2);
    wait_bs(2, "r1_bs_timeout");
    check_eq("resync_shorten_bit", gap(0), 14);

    // Wrong-direction request ignored, then over-shortening ends PHASE2 at the next tick.
    clear_q(); wait_bs(1, "os_sync_timeout");
    wait_seg(3, 0, "os_ph2_timeout");
    pulse_rr(0, 5);
    wait_seg(3, 1, "os_qc1_timeout");
    pulse_rr(1, 3);
    wait_bs(2, "os_bs_timeout");
    check_eq("overshorten_bit", gap(0), 16);

    // Only one resync per bit.
    clear_q(); wait_bs(1, "once_sync_timeout");
    wait_seg(1, -1, "once_prop_timeout");
    pulse_rr(0, 2);
    wait_seg(3, 0, "once_ph2_timeout");
    pulse_rr(1, 2);
    wait_bs(2, "once_bs_timeout");
    check_eq("once_per_bit", gap(0), 22);

    // Hard sync together with resync mid-PHASE1.
    clear_q(); wait_bs(1, "hs_sync_timeout");
    wait_seg(2, 1, "hs_ph1_timeout");
    hard_sync_request = 1; resync_required = 1; resync_direction = 0; resync_adjustment = 2;
    step();
    hard_sync_request = 0; resync_required = 0;
    check_eq("hs_segment", int'(current_segment), 0);
    check_eq("hs_quanta", int'(quanta_counter), 0);
    check_eq("hs_bit_start", int'(bit_start), 1);
    check_eq("hs_tick", int'(time_quantum_tick), 0);
    step(); step();
    check_eq("hs_prop_after2", int'(current_segment), 1);
    wait_bs(3, "hs_bs_timeout");
    check_eq("hs_bit_nominal", gap(1), 18);

    // No PROP: 7 tq bits, then a reset in PHASE2.
    enable = 0; step();
    set_cfg(1, 0, 3, 3);
    enable = 1; clear_q();
    wait_bs(3, "p0_bs_timeout");
    check_eq("prop0_period0", gap(0), 14);
    check_eq("prop0_period1", gap(1), 14);
    wait_seg(3, -1, "rst_ph2_timeout");
    reset = 1; step();
    check_eq("midrst_segment", int'(current_segment), 0);
    check_eq("midrst_quanta", int'(quanta_counter), 0);
    check_eq("midrst_tick", int'(time_quantum_tick), 0);
    check_eq("midrst_sample", int'(sample_point), 0);
    check_eq("midrst_bit_start", int'(bit_start), 0);
    reset = 0; clear_q();
    wait_bs(2, "resume_bs_timeout");
    check_eq("resume_period", gap(0), 14);

    // Randomized traffic against the model.
    for (int round = 0; round < 10; round++) begin
      enable = 0; step();
      set_cfg(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 6)), int'($urandom_range(0, 6)));
      enable = 1;
      for (int c = 0; c < 300; c++) begin
        int r;
        r = int'($urandom_range(0, 99));
        hard_sync_request = (r < 2);
        reset             = (r == 2);
        enable            = (r != 3);
        resync_required   = (r >= 4 && r < 20);
        resync_direction  = 1'($urandom_range(0, 1));
        resync_adjustment = 4'($urandom_range(0, 5));
        step();
      end
      hard_sync_request = 0; reset = 0; resync_required = 0; enable = 1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
